// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-style control unit: Moore FSM decoding datapath controls from the current state.
// Optional macro MCYCLE_CTRL_MEMWAIT_EN makes FETCH/MEMRD/MEMWR wait on mem_ready; otherwise memory is single-cycle.
module mcycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic        mem_ready,
    output logic        PCW,
    output logic        PCWC,
    output logic        IRW,
    output logic        IorD,
    output logic        MemR,
    output logic        MemW,
    output logic        RegW,
    output logic        SA,
    output logic [1:0]  SB,
    output logic [1:0]  ALUOP,
    output logic [1:0]  RegDst,
    output logic [1:0]  Mem2Reg,
    output logic [1:0]  PC_S,
    output logic        br_ne,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic [31:0] retire_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10,
        S_IEX    = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    state_t cur;
    state_t nxt;
    logic   ready;

`ifdef MCYCLE_CTRL_MEMWAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    assign state = 4'(cur);

    // State register and retirement counter; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= S_FETCH;
            retire_cnt <= '0;
        end else begin
            cur <= nxt;
            if (instr_done) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode; everything stays 0 while in reset
    always_comb begin
        nxt        = cur;
        PCW        = 1'b0;
        PCWC       = 1'b0;
        IRW        = 1'b0;
        IorD       = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        RegW       = 1'b0;
        SA         = 1'b0;
        SB         = 2'b00;
        ALUOP      = 2'b00;
        RegDst     = 2'b00;
        Mem2Reg    = 2'b00;
        PC_S       = 2'b00;
        br_ne      = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    MemR = 1'b1;
                    SB   = 2'b01;
                    IRW  = ready;
                    PCW  = ready;
                    nxt  = ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    SB = 2'b11;
                    case (OP)
                        6'h00:        nxt = S_REX;
                        6'h02:        nxt = S_JUMP;
                        6'h03:        nxt = S_JAL;
                        6'h04, 6'h05: nxt = S_BRANCH;
                        6'h23, 6'h2B: nxt = S_MEMADR;
                        default:      nxt = S_IEX;
                    endcase
                end
                S_MEMADR: begin
                    SA  = 1'b1;
                    SB  = 2'b10;
                    nxt = (OP == 6'h23) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    MemR = 1'b1;
                    IorD = 1'b1;
                    nxt  = ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    RegW       = 1'b1;
                    Mem2Reg    = 2'b01;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_MEMWR: begin
                    MemW       = 1'b1;
                    IorD       = 1'b1;
                    instr_done = ready;
                    nxt        = ready ? S_FETCH : S_MEMWR;
                end
                S_REX: begin
                    SA    = 1'b1;
                    ALUOP = 2'b10;
                    nxt   = S_RWB;
                end
                S_RWB: begin
                    RegW       = 1'b1;
                    RegDst     = 2'b01;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_BRANCH: begin
                    SA         = 1'b1;
                    ALUOP      = 2'b01;
                    PCWC       = 1'b1;
                    PC_S       = 2'b01;
                    br_ne      = (OP == 6'h05);
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_JUMP: begin
                    PCW        = 1'b1;
                    PC_S       = 2'b10;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_JAL: begin
                    PCW        = 1'b1;
                    PC_S       = 2'b10;
                    RegW       = 1'b1;
                    RegDst     = 2'b10;
                    Mem2Reg    = 2'b10;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                S_IEX: begin
                    SA    = 1'b1;
                    SB    = 2'b10;
                    ALUOP = 2'b11;
                    nxt   = S_IWB;
                end
                S_IWB: begin
                    RegW       = 1'b1;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: instruction-path model checked every cycle plus literal expectations.
// Honours MCYCLE_CTRL_MEMWAIT_EN the same way the design does.
module tb_mcycle_ctrl;

`ifdef MCYCLE_CTRL_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OP;
    logic        mem_ready;
    logic        PCW, PCWC, IRW, IorD, MemR, MemW, RegW, SA, br_ne, instr_done;
    logic [1:0]  SB, ALUOP, RegDst, Mem2Reg, PC_S;
    logic [3:0]  state;
    logic [31:0] retire_cnt;

    mcycle_ctrl dut (
        .clk(clk), .rst(rst), .OP(OP), .mem_ready(mem_ready),
        .PCW(PCW), .PCWC(PCWC), .IRW(IRW), .IorD(IorD), .MemR(MemR), .MemW(MemW),
        .RegW(RegW), .SA(SA), .SB(SB), .ALUOP(ALUOP), .RegDst(RegDst),
        .Mem2Reg(Mem2Reg), .PC_S(PC_S), .br_ne(br_ne), .state(state),
        .instr_done(instr_done), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // {PCW,PCWC,IRW,IorD,MemR,MemW,RegW,SA,SB,ALUOP,RegDst,Mem2Reg,PC_S,br_ne,instr_done}
    logic [19:0] dut_ctl;
    assign dut_ctl = {PCW, PCWC, IRW, IorD, MemR, MemW, RegW, SA, SB, ALUOP,
                      RegDst, Mem2Reg, PC_S, br_ne, instr_done};

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a fixed list of phases; memory phases stretch while not ready
    function automatic logic [3:0] path_state(input logic [5:0] op, input int idx);
        logic [3:0] p [5];
        case (op)
            6'h00:        p = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
            6'h02:        p = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
            6'h03:        p = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0};
            6'h04, 6'h05: p = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
            6'h23:        p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'h2B:        p = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
            default:      p = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd0};
        endcase
        return p[idx];
    endfunction

    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'h02, 6'h03, 6'h04, 6'h05: return 3;
            6'h23:                      return 5;
            default:                    return 4;
        endcase
    endfunction

    function automatic logic eff_ready(input logic mr);
        return MEMWAIT ? mr : 1'b1;
    endfunction

    function automatic logic [19:0] exp_ctrl(input logic [3:0] s, input logic rdy,
                                             input logic [5:0] op, input logic r);
        logic pcw, pcwc, irw, iord, memr, memw, regw, sa, bne, done;
        logic [1:0] sb, aluop, rdst, m2r, pcs;
        {pcw, pcwc, irw, iord, memr, memw, regw, sa, bne, done} = '0;
        {sb, aluop, rdst, m2r, pcs} = '0;
        case (s)
            4'd0:  begin memr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin memr = 1; iord = 1; end
            4'd4:  begin regw = 1; m2r = 2'b01; done = 1; end
            4'd5:  begin memw = 1; iord = 1; done = rdy; end
            4'd6:  begin sa = 1; aluop = 2'b10; end
            4'd7:  begin regw = 1; rdst = 2'b01; done = 1; end
            4'd8:  begin sa = 1; aluop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == 6'h05); done = 1; end
            4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd10: begin pcw = 1; pcs = 2'b10; regw = 1; rdst = 2'b10; m2r = 2'b10; done = 1; end
            4'd11: begin sa = 1; sb = 2'b10; aluop = 2'b11; end
            4'd12: begin regw = 1; done = 1; end
            default: ;
        endcase
        if (r) return '0;
        return {pcw, pcwc, irw, iord, memr, memw, regw, sa, sb, aluop, rdst, m2r, pcs, bne, done};
    endfunction

    int          m_idx = 0;
    logic [31:0] m_cnt = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_idx <= 0;
            m_cnt <= '0;
        end else if (path_state(OP, m_idx) inside {4'd0, 4'd3, 4'd5} && !eff_ready(mem_ready)) begin
            m_idx <= m_idx;
        end else if (m_idx == path_len(OP) - 1) begin
            m_idx <= 0;
            m_cnt <= m_cnt + 32'd1;
        end else begin
            m_idx <= m_idx + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(path_state(OP, m_idx)));
            check("ctrl", 32'(dut_ctl),
                  32'(exp_ctrl(path_state(OP, m_idx), eff_ready(mem_ready), OP, rst)));
            check("retire_cnt", retire_cnt, m_cnt);
        end
    end

    logic [3:0]  tr_st  [32];
    logic [19:0] tr_ctl [32];

    // Runs one instruction from FETCH to retirement, stretching memory phases by 'waits' cycles
    task automatic run_instr(input logic [5:0] op, input int waits, input bit low, output int cycles);
        int waited;
        bit done;
        logic [19:0] ec;
        waited = 0;
        cycles = 0;
        done   = 1'b0;
        OP     = op;
        while (!done && cycles < 30) begin
            if (low)
                mem_ready = 1'b0;
            else if (path_state(OP, m_idx) inside {4'd3, 4'd5} && waited < waits) begin
                mem_ready = 1'b0;
                waited++;
            end else
                mem_ready = 1'b1;
            @(negedge clk);
            tr_st[cycles]  = state;
            tr_ctl[cycles] = dut_ctl;
            ec   = exp_ctrl(path_state(OP, m_idx), eff_ready(mem_ready), OP, rst);
            done = ec[0];
            @(posedge clk);
            #1;
            cycles++;
        end
        check("no_timeout", 32'(done), 32'd1);
        mem_ready = 1'b1;
    endtask

    int cyc;
    int pulses;

    initial begin
        rst = 1'b1;
        OP = 6'h00;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        check("reset_memr_forced", 32'(MemR), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type
        run_instr(6'h00, 0, 1'b0, cyc);
        check("rtype_cycles", 32'(cyc), 32'd4);
        check("rtype_trace", {16'd0, tr_st[0], tr_st[1], tr_st[2], tr_st[3]}, 32'h0167);
        check("rtype_rwb_regw", 32'(tr_ctl[3][13]), 32'd1);
        check("rtype_rwb_regdst", 32'(tr_ctl[3][7:6]), 32'd1);
        check("rtype_cnt", retire_cnt, 32'd1);

        // LW with two MEMRD wait cycles
        run_instr(6'h23, 2, 1'b0, cyc);
        check("lw_cycles", 32'(cyc), MEMWAIT ? 32'd7 : 32'd5);
        check("lw_m2r", 32'(tr_ctl[cyc-1][5:4]), 32'd1);

        // BEQ then BNE
        run_instr(6'h04, 0, 1'b0, cyc);
        check("beq_cycles", 32'(cyc), 32'd3);
        check("beq_pcwc", 32'(tr_ctl[2][18]), 32'd1);
        check("beq_pcs", 32'(tr_ctl[2][3:2]), 32'd1);
        check("beq_brne", 32'(tr_ctl[2][1]), 32'd0);
        run_instr(6'h05, 0, 1'b0, cyc);
        check("bne_cycles", 32'(cyc), 32'd3);
        check("bne_brne", 32'(tr_ctl[2][1]), 32'd1);

        // JAL
        run_instr(6'h03, 0, 1'b0, cyc);
        check("jal_cycles", 32'(cyc), 32'd3);
        check("jal_fields", 32'({tr_ctl[2][19], tr_ctl[2][13], tr_ctl[2][7:6], tr_ctl[2][5:4]}),
              32'b1_1_10_10);
        pulses = 0;
        for (int i = 0; i < cyc; i++) pulses += int'(tr_ctl[i][0]);
        check("jal_done_pulses", 32'(pulses), 32'd1);

        // Jump and I-type
        run_instr(6'h02, 0, 1'b0, cyc);
        check("j_cycles", 32'(cyc), 32'd3);
        run_instr(6'h08, 0, 1'b0, cyc);
        check("itype_cycles", 32'(cyc), 32'd4);

        // SW: mem_ready held low when it is ignored, one wait cycle otherwise
        run_instr(6'h2B, MEMWAIT ? 1 : 0, !MEMWAIT, cyc);
        check("sw_cycles", 32'(cyc), MEMWAIT ? 32'd5 : 32'd4);
        check("sw_cnt", retire_cnt, 32'd8);

        // Reset in the middle of MEMWR with mem_ready low
        OP = 6'h2B;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_state", 32'(state), 32'd5);
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_memw", 32'(MemW), 32'd0);
        check("rst_done", 32'(instr_done), 32'd0);
        @(posedge clk);
        #1;
        check("rst_next_state", 32'(state), 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;

        run_instr(6'h00, 0, 1'b0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd4);
        check("post_rst_cnt", retire_cnt, 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset; synchronous and active-high.
REQ-003 OP  in  6  opcode from the instruction register; stable from DECODE until the instruction retires.
REQ-004 mem_ready  in  1  memory handshake; 1 means the access posted this cycle completes this cycle.
REQ-005 PCW, PCWC, IRW, IorD, MemR, MemW, RegW  out  1 each  PC write, conditional PC write, IR write, address select (0=PC, 1=ALUOut), memory read, memory write, register write.
REQ-006 SA  out  1  ALU A select: 0=PC, 1=reg A.
REQ-007 SB  out  2  ALU B select: 00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2.
REQ-008 ALUOP  out  2  00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded.
REQ-009 RegDst  out  2  00=rt, 01=rd, 10=$31.
REQ-010 Mem2Reg  out  2  write-back data: 00=ALUOut, 01=MDR, 10=PC.
REQ-011 PC_S  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
REQ-012 br_ne  out  1  1 = branch on not-equal, 0 = branch on equal.
REQ-013 state  out  4  current state encoding.
REQ-014 instr_done  out  1  one-cycle pulse in the retiring cycle.
REQ-015 retire_cnt  out  32  count of retired instructions.

Function
REQ-016 Moore FSM: 4-bit state register; all outputs are combinational decodes of state, with mem_ready gating only where stated; any output not listed for a state is 0.
REQ-017 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BRANCH=8, JUMP=9, JAL=10, IEX=11, IWB=12.
REQ-018 FETCH: MemR=1, IorD=0, SA=0, SB=01, ALUOP=00, PC_S=00, IRW=PCW=mem_ready; go to DECODE if mem_ready, else hold.
REQ-019 DECODE: SA=0, SB=11, ALUOP=00. Next state: OP 0x00->REX; 0x02->JUMP; 0x03->JAL; 0x04/0x05->BRANCH; 0x23/0x2B->MEMADR; any other OP->IEX.
REQ-020 MEMADR: SA=1, SB=10, ALUOP=00; next state MEMRD if OP=0x23, else MEMWR.
REQ-021 MEMRD: MemR=1, IorD=1; go to MEMWB on mem_ready, else hold.
REQ-022 MEMWB: RegW=1, RegDst=00, Mem2Reg=01; go to FETCH; retires.
REQ-023 MEMWR: MemW=1, IorD=1; go to FETCH on mem_ready (retires), else hold.
REQ-024 REX: SA=1, SB=00, ALUOP=10; go to RWB. RWB: RegW=1, RegDst=01, Mem2Reg=00; go to FETCH; retires.
REQ-025 BRANCH: SA=1, SB=00, ALUOP=01, PCWC=1, PC_S=01, br_ne=(OP==0x05); go to FETCH; retires.
REQ-026 JUMP: PCW=1, PC_S=10; go to FETCH; retires. JAL: PCW=1, PC_S=10, RegW=1, RegDst=10, Mem2Reg=10; go to FETCH; retires.
REQ-027 IEX: SA=1, SB=10, ALUOP=11; go to IWB. IWB: RegW=1, RegDst=00, Mem2Reg=00; go to FETCH; retires.
REQ-028 Unused encodings 13-15: all outputs 0; next state FETCH.
REQ-029 instr_done=1 in each retiring state cycle (gated by mem_ready in MEMWR); retire_cnt increments by 1 on that cycle's edge and wraps 0xFFFFFFFF->0.
REQ-030 Cycle counts with no memory wait: LW=5, SW=4, R/I-type=4, branch/jump/JAL=3.

Reset
REQ-031 rst high at an edge: state<=FETCH and retire_cnt<=0, overriding any other update in that cycle, including mid-instruction.
REQ-032 While rst is high, all control outputs and instr_done are forced to 0.

Configuration
REQ-033 Macro MCYCLE_CTRL_MEMWAIT_EN defined: mem_ready is honoured as specified above.
REQ-034 Macro not defined: mem_ready is internally treated as 1 (FETCH, MEMRD and MEMWR each last exactly one cycle); the port remains present but is ignored.

Verification
REQ-035 Reset, OP=0x00, mem_ready=1 -> state 0,1,6,7,0; RegW=1 with RegDst=01 in state 7; retire_cnt=1.
REQ-036 OP=0x23, mem_ready=0 for the first 2 cycles of MEMRD (macro on) -> MEMRD lasts 3 cycles; 7 cycles total; Mem2Reg=01 in MEMWB.
REQ-037 OP=0x04 then OP=0x05 -> PCWC=1, PC_S=01 in BRANCH; br_ne=0, then br_ne=1; each instruction takes 3 cycles.
REQ-038 OP=0x03 -> JAL state asserts PCW=1, RegW=1, RegDst=10, Mem2Reg=10; instr_done pulses once.
REQ-039 rst asserted during MEMWR with mem_ready=0 -> next state FETCH, MemW=0 while rst is high, retire_cnt=0.
REQ-040 Macro off, mem_ready held at 0, OP=0x2B -> SW completes in 4 cycles; retire_cnt increments.
